sccb_master: RTL and testbench
==============================

Name: sccb_master

Overview:
- Parametrised SCCB/I2C-style master for OmniVision camera register access.
- Successor to the write-only register sender. Adds:
  - a programmable bus-clock divider;
  - 3-phase write and 2+2-phase read transactions;
  - a true open-drain SIOD with ACK sampling;
  - a busy/done handshake with read-data return.
- Sits between the camera init/config sequencer and the OV7670 SIOC/SIOD pins.

Parameters:
- CLK_DIV, 64: clk cycles per quarter bit-slot; legal range ≥2. One slot = 4*CLK_DIV cycles.
- STARTUP_DELAY, 254: clk cycles after reset release before the first transaction is accepted.
- ACK_CHECK, 1: 1 = ACK slots sampled into nack; 0 = nack forced 0.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  request; sampled only when busy=0.
- rw  in  1  0 = write, 1 = read; captured with start.
- id  in  8  device address; bit0 ignored (forced 0 in write phase, 1 in read phase).
- regis  in  8  register sub-address.
- wdata  in  8  write data.
- busy  out  1  high during startup and while a transaction runs.
- done  out  1  one-cycle pulse at transaction end.
- rdata  out  8  read byte; valid from done until next accept.
- nack  out  1  sticky over the transaction; valid with done.
- sioc  out  1  SCCB clock, push-pull.
- siod  inout  1  SCCB data, open-drain: driven 0 or high-Z only.

Behaviour:
- Reset (async, immediate):
  - sioc=1, siod=Z, busy=1, done=0, rdata=0, nack=0.
  - Startup counter cleared; state=STARTUP.
- STARTUP:
  - Count STARTUP_DELAY cycles, then go to IDLE with busy=0.
  - start is ignored during STARTUP.
- IDLE: sioc=1, siod=Z.
- Accept: start=1 while in IDLE.
  - On that edge, capture rw/id/regis/wdata and clear nack.
  - busy=1 from the next cycle.
  - start while busy=1 is ignored and has no queueing.
- Slot waveforms, quarter q0..q3, each CLK_DIV cycles:
  - START: q0,q1 siod=Z sioc=1; q2 siod=0 sioc=1; q3 siod=0 sioc=0.
  - BIT: q0 sioc=0 siod=bit (0→drive 0, 1→Z); q1,q2 sioc=1; q3 sioc=0; siod held for all four quarters.
  - Sample siod on the last clk of q1.
  - STOP: q0 sioc=0 siod=0; q1 sioc=1 siod=0; q2,q3 sioc=1 siod=Z.
- Bytes are sent MSB first. Each byte is followed by a 9th slot.
  - Master-sent bytes: 9th slot is an ACK slot, siod=Z, sampled.
- Write sequence:
  - START, {id[7:1],0}+ACK, regis+ACK, wdata+ACK, STOP = 29 slots.
- Read sequence:
  - START, {id[7:1],0}+ACK, regis+ACK, STOP;
  - then START, {id[7:1],1}+ACK, 8 read bits with siod=Z, sampled into rdata MSB first;
  - then NA slot with master siod=Z, not recorded; STOP = 40 slots.
- nack:
  - OR of all sampled ACK-slot values (1 = no acknowledge).
  - Does not abort the transaction (SCCB "don't care" bit tolerant).
  - ACK_CHECK=0 → nack stays 0.
- Completion:
  - done=1 on the cycle after the final STOP slot's last clk; busy=0 on that same cycle; state=IDLE.
  - A new start may be accepted on the done cycle.
- Latency, accept edge to done:
  - write: 29*4*CLK_DIV+1 cycles;
  - read: 40*4*CLK_DIV+1 cycles.
- Counters:
  - quarter counter ceil(log2(CLK_DIV)) bits wrapping at CLK_DIV-1;
  - 2-bit quarter index;
  - 6-bit slot index;
  - no other wrap behaviour.
- Reset mid-transaction:
  - Bus is released immediately (sioc=1, siod=Z) with no STOP generated.
  - No done pulse; STARTUP delay re-runs.

Test Plan:
- CLK_DIV=4, STARTUP_DELAY=10, slave model ACKs. Write id=0x42 regis=0x12 wdata=0x80 → first accepted start at cycle 10 after reset. Bus decodes 0x42,0x12,0x80; done at +465 cycles; nack=0; siod never driven 1.
- Read id=0x43 regis=0x0A, slave returns 0xA5 → bus shows 0x42,0x0A, STOP/START, 0x43. done at +641 cycles; rdata=0xA5, nack=0.
- No slave (siod pulled up): write → nack=1 at done, all 29 slots still generated. Repeat with ACK_CHECK=0 → nack=0.
- start pulsed every cycle during a write → exactly one transaction. Next accept occurs on the done cycle; done pulses once per transaction.
- start during STARTUP → ignored, busy=1 throughout; a start at cycle STARTUP_DELAY is accepted.
- Assert reset at slot 12 of a write → same cycle sioc=1, siod=Z, busy=1; no done pulse; after STARTUP_DELAY a fresh write completes correctly.

Source files
------------

// File: rtl/sccb_master.sv
`timescale 1ns/1ps
// sccb_master: SCCB/I2C-style register master for OmniVision camera config (3-phase write, 2+2-phase read).
// Latency: accept edge to done = 29*4*CLK_DIV+1 cycles (write) or 40*4*CLK_DIV+1 cycles (read).
// Backpressure: start is taken only while busy=0; requests while busy are dropped, nothing is queued.
// Ports: clk/reset (async, active-high); start/rw/id/regis/wdata request side;
//        busy/done/rdata/nack result side; sioc push-pull clock, siod open-drain data (0 or Z only).
module sccb_master #(
    parameter int CLK_DIV       = 64,   // clk cycles per quarter slot, >= 2
    parameter int STARTUP_DELAY = 254,  // cycles after reset before first accept, >= 1
    parameter int ACK_CHECK     = 1     // 1: ACK slots feed nack, 0: nack stays 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [7:0] id,
    input  logic [7:0] regis,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       nack,
    output logic       sioc,
    inout  wire        siod
);

    localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SW = (STARTUP_DELAY > 1) ? $clog2(STARTUP_DELAY + 1) : 1;
    localparam logic [QW-1:0] Q_LAST  = QW'(CLK_DIV - 1);
    localparam logic [SW-1:0] SU_LAST = SW'(STARTUP_DELAY - 1);

    localparam logic [1:0] ST_STARTUP = 2'd0;
    localparam logic [1:0] ST_IDLE    = 2'd1;
    localparam logic [1:0] ST_PREP    = 2'd2;  // one idle-bus cycle between accept and the first slot
    localparam logic [1:0] ST_RUN     = 2'd3;

    logic [1:0]    state;
    logic [SW-1:0] su_cnt;
    logic [QW-1:0] q_cnt;
    logic [1:0]    quarter;
    logic [5:0]    slot;

    logic          rw_r;
    logic [7:0]    id_r;
    logic [7:0]    regis_r;
    logic [7:0]    wdata_r;

    logic [7:0]    id_w;
    logic [7:0]    id_rd;
    logic [5:0]    last_slot;
    logic          k_start;
    logic          k_stop;
    logic          k_ack;
    logic          k_rd;
    logic          bit_val;
    logic          drive_low;
    logic          q_end;
    logic          sample_pt;

    // Address bit0 is the direction bit on the wire, never the caller's value.
    assign id_w      = id_r & 8'hFE;
    assign id_rd     = id_r | 8'h01;
    assign last_slot = rw_r ? 6'd39 : 6'd28;
    assign busy      = (state != ST_IDLE);
    assign q_end     = (q_cnt == Q_LAST);
    assign sample_pt = q_end && (quarter == 2'd1);

    // Slot map. Write: 0 S, 1-8 addr, 9 A, 10-17 reg, 18 A, 19-26 data, 27 A, 28 P.
    // Read adds: 19 P, 20 S, 21-28 addr|1, 29 A, 30-37 read bits, 38 NA, 39 P.
    always_comb begin
        k_start = 1'b0;
        k_stop  = 1'b0;
        k_ack   = 1'b0;
        k_rd    = 1'b0;
        bit_val = 1'b1;  // released unless a 0 data bit is being sent
        if (slot == 6'd0 || (rw_r && slot == 6'd20)) begin
            k_start = 1'b1;
        end else if (slot == last_slot || (rw_r && slot == 6'd19)) begin
            k_stop = 1'b1;
        end else if (slot <= 6'd8) begin
            bit_val = id_w[3'(6'd8 - slot)];
        end else if (slot == 6'd9 || slot == 6'd18) begin
            k_ack = 1'b1;
        end else if (slot <= 6'd17) begin
            bit_val = regis_r[3'(6'd17 - slot)];
        end else if (!rw_r) begin
            if (slot <= 6'd26) begin
                bit_val = wdata_r[3'(6'd26 - slot)];
            end else begin
                k_ack = 1'b1;
            end
        end else begin
            if (slot <= 6'd28) begin
                bit_val = id_rd[3'(6'd28 - slot)];
            end else if (slot == 6'd29) begin
                k_ack = 1'b1;
            end else if (slot <= 6'd37) begin
                k_rd = 1'b1;
            end
            // slot 38 is the master NA: released and not recorded
        end
    end

    // Pin waveforms per quarter; outside RUN the bus is released and SIOC idles high.
    always_comb begin
        sioc      = 1'b1;
        drive_low = 1'b0;
        if (state == ST_RUN) begin
            if (k_start) begin
                sioc      = (quarter != 2'd3);
                drive_low = quarter[1];
            end else if (k_stop) begin
                sioc      = (quarter != 2'd0);
                drive_low = !quarter[1];
            end else begin
                sioc      = (quarter == 2'd1) || (quarter == 2'd2);
                drive_low = !bit_val;
            end
        end
    end

    assign siod = drive_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_STARTUP;
            su_cnt  <= '0;
            q_cnt   <= '0;
            quarter <= 2'd0;
            slot    <= 6'd0;
            done    <= 1'b0;
            rdata   <= 8'h00;
            nack    <= 1'b0;
            rw_r    <= 1'b0;
            id_r    <= 8'h00;
            regis_r <= 8'h00;
            wdata_r <= 8'h00;
        end else begin
            done <= 1'b0;
            case (state)
                ST_STARTUP: begin
                    if (su_cnt == SU_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        su_cnt <= su_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (start) begin
                        rw_r    <= rw;
                        id_r    <= id;
                        regis_r <= regis;
                        wdata_r <= wdata;
                        nack    <= 1'b0;
                        q_cnt   <= '0;
                        quarter <= 2'd0;
                        slot    <= 6'd0;
                        state   <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    state <= ST_RUN;
                end
                default: begin  // ST_RUN
                    if (sample_pt) begin
                        // A high ACK is a missing acknowledge; it is recorded but never aborts.
                        if (k_ack && ACK_CHECK != 0) begin
                            nack <= nack | siod;
                        end
                        if (k_rd) begin
                            rdata <= {rdata[6:0], siod};
                        end
                    end
                    if (q_end) begin
                        q_cnt   <= '0;
                        quarter <= quarter + 2'd1;
                        if (quarter == 2'd3) begin
                            if (slot == last_slot) begin
                                state <= ST_IDLE;
                                done  <= 1'b1;
                            end else begin
                                slot <= slot + 6'd1;
                            end
                        end
                    end else begin
                        q_cnt <= q_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sccb_master.sv
`timescale 1ns/1ps
// tb_sccb_master: scoreboard bench with an I2C-level slave/decoder model on the wires.
// Expected results (latency, nack, rdata, decoded bus bytes) are queued at issue time
// and popped by an independent monitor whenever done pulses.
module tb_sccb_master;

    localparam int D    = 4;
    localparam int SD   = 10;
    localparam int WLAT = 29 * 4 * D + 1;
    localparam int RLAT = 40 * 4 * D + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [7:0] id = 8'h00;
    logic [7:0] regis = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       nack;
    logic       sioc;
    wire        siod;

    // second instance with ACK checking disabled and no slave on its bus
    logic       start2 = 1'b0;
    logic       busy2;
    logic       done2;
    logic [7:0] rdata2;
    logic       nack2;
    logic       sioc2;
    wire        siod2;

    logic       slave_low = 1'b0;
    pullup (siod);
    pullup (siod2);
    assign siod = slave_low ? 1'b0 : 1'bz;

    sccb_master #(.CLK_DIV(D), .STARTUP_DELAY(SD), .ACK_CHECK(1)) dut (
        .clk(clk), .reset(reset), .start(start), .rw(rw), .id(id), .regis(regis),
        .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .nack(nack),
        .sioc(sioc), .siod(siod)
    );

    sccb_master #(.CLK_DIV(D), .STARTUP_DELAY(SD), .ACK_CHECK(0)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .rw(1'b0), .id(8'h42), .regis(8'h12),
        .wdata(8'h80), .busy(busy2), .done(done2), .rdata(rdata2), .nack(nack2),
        .sioc(sioc2), .siod(siod2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         acc;
        bit         is_rd;
        logic [7:0] rd;
        bit         nk;
        int         lat;
        int         ntok;
    } exp_t;

    exp_t sbq[$];
    int   exp_tok[$];   // -1 START, -2 STOP, else byte + 256*ninth_bit
    int   obs_tok[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    bit         ack_en = 1'b1;
    logic [7:0] rd_val = 8'h00;

    task automatic check(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d", nm, act, act, req, req, cyc);
        end
    endtask

    function automatic int siod_bit(input logic v);
        return (v === 1'b0) ? 0 : 1;
    endfunction

    // Bus-level slave and decoder: START/STOP by SIOD edges while SIOC high,
    // bits on SIOC rise, slave drives on SIOC fall.
    logic [8:0] sh = 9'h0;
    int         bitcnt = 0;
    int         byte_no = 0;
    bit         rd_pending = 1'b0;
    bit         rd_active = 1'b0;

    initial begin : bus_model
        logic pc, pd, c, d;
        pc = 1'b1;
        pd = 1'b1;
        forever begin
            @(sioc or siod);
            c = sioc;
            d = siod_bit(siod) != 0;
            if (pc && c && pd && !d) begin
                obs_tok.push_back(-1);
                bitcnt = 0; byte_no = 0; rd_pending = 1'b0; rd_active = 1'b0; slave_low = 1'b0;
            end else if (pc && c && !pd && d) begin
                obs_tok.push_back(-2);
                bitcnt = 0; slave_low = 1'b0;
            end else if (!pc && c) begin
                sh = {sh[7:0], d};
                bitcnt++;
                if (bitcnt == 9) begin
                    obs_tok.push_back(int'(sh[8:1]) + (sh[0] ? 256 : 0));
                    if (byte_no == 0 && sh[1]) rd_pending = 1'b1;
                    byte_no++;
                    bitcnt = 0;
                end
            end else if (pc && !c) begin
                if (bitcnt == 8) begin
                    slave_low = ack_en && !rd_active;
                end else if (bitcnt == 0 && byte_no > 0) begin
                    if (rd_pending) begin
                        rd_active = 1'b1; rd_pending = 1'b0; slave_low = !rd_val[7];
                    end else begin
                        rd_active = 1'b0; slave_low = 1'b0;
                    end
                end else if (rd_active && bitcnt >= 1 && bitcnt <= 7) begin
                    slave_low = !rd_val[7 - bitcnt];
                end
            end
            pc = c;
            pd = d;
        end
    end

    initial begin : monitor
        exp_t e;
        int   got;
        forever begin
            @(negedge clk);
            if (!reset && done) begin
                if (sbq.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check("latency", cyc - e.acc, e.lat);
                    check("nack", int'(nack), int'(e.nk));
                    if (e.is_rd) check("rdata", int'(rdata), int'(e.rd));
                    for (int k = 0; k < e.ntok; k++) begin
                        got = (obs_tok.size() > 0) ? obs_tok.pop_front() : -99;
                        check("bus_token", got, exp_tok.pop_front());
                    end
                end
            end
        end
    end

    task automatic push_exp(input bit r, input logic [7:0] i, input logic [7:0] rg,
                            input logic [7:0] wd, input logic [7:0] rv, input bit ack, input int acc);
        exp_t e;
        int   nb;
        nb = ack ? 0 : 256;
        e.acc = acc; e.is_rd = r; e.rd = rv; e.nk = !ack; e.lat = r ? RLAT : WLAT;
        exp_tok.push_back(-1);
        exp_tok.push_back(int'(i & 8'hFE) + nb);
        exp_tok.push_back(int'(rg) + nb);
        if (r) begin
            exp_tok.push_back(-2);
            exp_tok.push_back(-1);
            exp_tok.push_back(int'(i | 8'h01) + nb);
            exp_tok.push_back(int'(rv) + 256);  // master NA leaves the line high
            exp_tok.push_back(-2);
            e.ntok = 8;
        end else begin
            exp_tok.push_back(int'(wd) + nb);
            exp_tok.push_back(-2);
            e.ntok = 5;
        end
        sbq.push_back(e);
    endtask

    task automatic issue(input bit r, input logic [7:0] i, input logic [7:0] rg, input logic [7:0] wd,
                         input logic [7:0] rv, input bit ack, output int acc);
        int g = 0;
        @(negedge clk);
        while (busy !== 1'b0 && g < 5000) begin @(negedge clk); g++; end
        acc = cyc + 1;
        if (g >= 5000) begin
            check("idle_timeout", 0, 1);
        end else begin
            rw = r; id = i; regis = rg; wdata = wd; rd_val = rv; ack_en = ack; start = 1'b1;
            push_exp(r, i, rg, wd, rv, ack, acc);
            @(negedge clk);
            start = 1'b0;
            check("busy_after_accept", int'(busy), 1);
        end
    endtask

    task automatic wait_startup(input int r);
        int g = 0;
        while (busy !== 1'b0 && g < 1000) begin @(negedge clk); g++; end
        check("startup_len", cyc - r, SD);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int acc, r, g, a2;
        // reset state, with a request already pending that startup must ignore
        start = 1'b1; rw = 1'b0; id = 8'h42; regis = 8'h12; wdata = 8'h80; ack_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_sioc", int'(sioc), 1);
        check("rst_siod", siod_bit(siod), 1);
        check("rst_busy", int'(busy), 1);
        check("rst_done", int'(done), 0);
        check("rst_rdata", int'(rdata), 0);
        check("rst_nack", int'(nack), 0);
        reset = 1'b0;
        r = cyc;
        wait_startup(r);
        push_exp(1'b0, 8'h42, 8'h12, 8'h80, 8'h00, 1'b1, cyc + 1);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_first_accept", int'(busy), 1);

        issue(1'b1, 8'h43, 8'h0A, 8'h00, 8'hA5, 1'b1, acc);   // read, slave answers 0xA5
        issue(1'b0, 8'h42, 8'h12, 8'h80, 8'h00, 1'b0, acc);   // no slave: every ACK high

        // start held high for a whole write: one transaction, then one on the done cycle
        issue(1'b0, 8'h42, 8'h55, 8'hC3, 8'h00, 1'b1, acc);
        start = 1'b1;
        g = 0;
        while (done !== 1'b1 && g < 2000) begin @(negedge clk); g++; end
        check("b2b_done_seen", int'(g < 2000), 1);
        check("busy_on_done", int'(busy), 0);
        push_exp(1'b0, 8'h42, 8'h55, 8'hC3, 8'h00, 1'b1, cyc + 1);
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", int'(busy), 1);

        for (int k = 0; k < 6; k++) begin
            bit rr;
            rr = 1'($urandom_range(0, 1));
            issue(rr, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                  rr ? 1'b1 : 1'($urandom_range(0, 1)), acc);
        end

        // abort a write in slot 12
        issue(1'b0, 8'h21, 8'h34, 8'h56, 8'h00, 1'b1, acc);
        while (cyc < acc + 1 + 12 * 4 * D + 2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_sioc", int'(sioc), 1);
        check("abort_siod", siod_bit(siod), 1);
        check("abort_busy", int'(busy), 1);
        check("abort_done", int'(done), 0);
        sbq.delete();
        exp_tok.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        r = cyc;
        wait_startup(r);
        obs_tok.delete();
        issue(1'b0, 8'h60, 8'h3C, 8'h0F, 8'h00, 1'b1, acc);

        // ACK checking disabled, bus with no slave
        g = 0;
        while (busy2 !== 1'b0 && g < 1000) begin @(negedge clk); g++; end
        start2 = 1'b1;
        a2 = cyc + 1;
        @(negedge clk);
        start2 = 1'b0;
        g = 0;
        while (done2 !== 1'b1 && g < 2000) begin @(negedge clk); g++; end
        check("ackoff_done_seen", int'(g < 2000), 1);
        check("ackoff_latency", cyc - a2, WLAT);
        check("ackoff_nack", int'(nack2), 0);

        g = 0;
        while (sbq.size() > 0 && g < 2000) begin @(negedge clk); g++; end
        check("scoreboard_drained", sbq.size(), 0);
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
